// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM port-0 arbiter.
// Lock state encoding plus owner-index width helper.
package sram_arb_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned MW_DEF = DW_DEF / 8;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_st_e;

  function automatic int unsigned owner_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// One-hot grant from a request vector, searching from a start pointer upward with wrap.
// With the pointer tied to zero this is a plain lowest-index-wins priority pick.
module arb_rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  localparam logic [2*N-1:0] One = {{(2*N-1){1'b0}}, 1'b1};

  logic [N-1:0]   mask;
  logic [N-1:0]   masked;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] dbl_gnt;

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(N); i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = req & mask;
    // Low half holds requests at/after the pointer, high half the wrapped-around ones.
    dbl     = {req, masked};
    dbl_gnt = dbl & (~dbl + One);
    gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
  end

endmodule

// File: rtl/sram_arb_rw.sv
// Arbiter/sequencer sharing SRAM port 0 between N_REQ requesters, with bus locking.
// Define SRAM_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module sram_arb_rw
  import sram_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*AW-1:0]       req_addr,
  input  logic [N_REQ*DW-1:0]       req_wdata,
  input  logic [N_REQ*(DW/8)-1:0]   req_wmask,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DW-1:0]             rsp_rdata,
  output logic                      sram_csb0,
  output logic                      sram_web0,
  output logic [DW/8-1:0]           sram_wmask0,
  output logic [AW-1:0]             sram_addr0,
  output logic [DW-1:0]             sram_din0,
  input  logic [DW-1:0]             sram_dout0
);

  localparam int unsigned MW = DW / 8;
  localparam int unsigned OW = owner_w(N_REQ);

  lock_st_e         lock_q;
  logic [OW-1:0]    owner_q;
  logic [N_REQ-1:0] rsp_q;

  logic [N_REQ-1:0] avail;
  logic [N_REQ-1:0] gnt;
  logic [OW-1:0]    g_idx;
  logic [OW-1:0]    ptr;
  logic             accept;

`ifdef SRAM_ARB_RR_EN
  logic [OW-1:0] ptr_q;
  logic [OW-1:0] ptr_nxt;
  assign ptr     = ptr_q;
  assign ptr_nxt = (g_idx == OW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
`else
  assign ptr = '0;
`endif

  // While locked only the owner is eligible; nothing is eligible during reset.
  always_comb begin
    avail = req_valid;
    if (lock_q == ST_LOCKED) begin
      avail          = '0;
      avail[owner_q] = req_valid[owner_q];
    end
    if (rst) begin
      avail = '0;
    end
  end

  arb_rr_pick #(
    .N  (N_REQ),
    .PW (OW)
  ) u_pick (
    .req (avail),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) begin
        g_idx = OW'(i);
      end
    end
  end

  assign accept    = |gnt;
  assign req_ready = gnt;

  // With no grant g_idx is 0, so the data path rests on requester 0's values.
  assign sram_csb0   = ~accept;
  assign sram_web0   = ~(accept & req_write[g_idx]);
  assign sram_addr0  = req_addr[g_idx*AW +: AW];
  assign sram_din0   = req_wdata[g_idx*DW +: DW];
  assign sram_wmask0 = req_wmask[g_idx*MW +: MW];

  assign rsp_valid = rst ? '0 : rsp_q;
  assign rsp_rdata = sram_dout0;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= ST_UNLOCKED;
      owner_q <= '0;
      rsp_q   <= '0;
`ifdef SRAM_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      rsp_q <= gnt & ~req_write;
      case (lock_q)
        ST_UNLOCKED: begin
          if (accept && req_lock[g_idx]) begin
            lock_q  <= ST_LOCKED;
            owner_q <= g_idx;
          end
        end
        ST_LOCKED: begin
          if (!req_valid[owner_q] || (accept && !req_lock[owner_q])) begin
            lock_q <= ST_UNLOCKED;
          end
        end
        default: lock_q <= ST_UNLOCKED;
      endcase
`ifdef SRAM_ARB_RR_EN
      // An owner's accepts keep pointing past it, so release lands on owner+1.
      if (accept) begin
        ptr_q <= ptr_nxt;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sram_arb_rw.sv
// Directed bench for sram_arb_rw with a behavioural 256x32 SRAM on port 0.
// Inputs change just after negedge; checks run 1 time unit later.
module tb_sram_arb_rw;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_write = '0;
  logic [N-1:0]      req_lock  = '0;
  logic [N*AW-1:0]   req_addr  = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N*MW-1:0]   req_wmask = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              sram_csb0;
  logic              sram_web0;
  logic [MW-1:0]     sram_wmask0;
  logic [AW-1:0]     sram_addr0;
  logic [DW-1:0]     sram_din0;
  logic [DW-1:0]     sram_dout0 = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem [256];

  always #5 clk = ~clk;

  sram_arb_rw #(
    .N_REQ (N),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  always @(posedge clk) begin : sram_model
    logic [DW-1:0] w;
    if (!sram_csb0) begin
      if (!sram_web0) begin
        w = mem[sram_addr0];
        for (int b = 0; b < int'(MW); b++) begin
          if (sram_wmask0[b]) w[b*8 +: 8] = sram_din0[b*8 +: 8];
        end
        mem[sram_addr0] <= w;
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_lock[i]           = l;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wmask[i*MW +: MW] = m;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [N-1:0]  exp_g [4];
  logic [N-1:0]  prev_g;
  logic [DW-1:0] exp_d;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
`ifdef SRAM_ARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif

    // Reset held with everyone requesting.
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h00, '0, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h00, '0, '0);
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      check_eq("rst_ready", 64'(req_ready), 64'(2'b00));
      check_eq("rst_csb", 64'(sram_csb0), 64'(1'b1));
      check_eq("rst_rsp", 64'(rsp_valid), 64'(2'b00));
    end
    step(); rst = 1'b0; #1;
    check_eq("post_rst_grant", 64'(req_ready), 64'(2'b01));
    check_eq("post_rst_csb", 64'(sram_csb0), 64'(1'b0));

    // Requester 1: masked write then read back.
    step();
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h33, '0, '0);
    set_req(1, 1'b1, 1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 4'b0101);
    #1;
    check_eq("rsp_after_rst_read", 64'(rsp_valid), 64'(2'b01));
    check_eq("wr_ready", 64'(req_ready), 64'(2'b10));
    check_eq("wr_web", 64'(sram_web0), 64'(1'b0));
    check_eq("wr_addr", 64'(sram_addr0), 64'(8'h10));
    check_eq("wr_din", 64'(sram_din0), 64'(32'hDEADBEEF));
    check_eq("wr_mask", 64'(sram_wmask0), 64'(4'b0101));
    step();
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h10, '0, '0);
    #1;
    check_eq("rd_ready", 64'(req_ready), 64'(2'b10));
    check_eq("rd_web", 64'(sram_web0), 64'(1'b1));
    check_eq("no_rsp_for_write", 64'(rsp_valid), 64'(2'b00));
    step();
    set_req(1, 1'b0, 1'b0, 1'b0, 8'h10, '0, '0);
    #1;
    check_eq("rd_rsp_valid", 64'(rsp_valid), 64'(2'b10));
    check_eq("rd_rsp_data", 64'(rsp_rdata), 64'(32'h00AD00EF));
    check_eq("idle_csb", 64'(sram_csb0), 64'(1'b1));
    check_eq("idle_web", 64'(sram_web0), 64'(1'b1));
    check_eq("idle_addr_req0", 64'(sram_addr0), 64'(8'h33));

    // Continuous reads from both requesters.
    prev_g = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step();
      set_req(0, 1'b1, 1'b0, 1'b0, 8'h20, '0, '0);
      set_req(1, 1'b1, 1'b0, 1'b0, 8'h10, '0, '0);
      #1;
      check_eq("rr_grant", 64'(req_ready), 64'(exp_g[k]));
      check_eq("rr_rsp", 64'(rsp_valid), 64'(prev_g));
      if (prev_g != 2'b00) begin
        exp_d = (prev_g == 2'b10) ? 32'h00AD00EF : 32'h0;
        check_eq("rr_rsp_data", 64'(rsp_rdata), 64'(exp_d));
      end
      prev_g = exp_g[k];
    end
    step();
    req_valid = '0;
    #1;
    check_eq("rr_last_rsp", 64'(rsp_valid), 64'(prev_g));

    // Requester 0 locks for 4 transfers while requester 1 waits.
    for (int k = 0; k < 4; k++) begin
      step();
      set_req(0, 1'b1, 1'b1, (k < 3), 8'(8'h40 + k), 32'(k), 4'hF);
      set_req(1, 1'b1, 1'b0, 1'b0, 8'h10, '0, '0);
      #1;
      check_eq("lock_grant_owner", 64'(req_ready), 64'(2'b01));
    end
    step();
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h00, '0, '0);
    #1;
    check_eq("lock_release_grant", 64'(req_ready), 64'(2'b10));

    // Locked owner drops valid for one cycle.
    step();
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h20, '0, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h10, '0, '0);
    #1;
    check_eq("lock2_take", 64'(req_ready), 64'(2'b01));
    step();
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h20, '0, '0);
    #1;
    check_eq("lock2_drop_ready", 64'(req_ready), 64'(2'b00));
    check_eq("lock2_drop_csb", 64'(sram_csb0), 64'(1'b1));
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h20, '0, '0);
    #1;
`ifdef SRAM_ARB_RR_EN
    check_eq("lock2_after", 64'(req_ready), 64'(2'b10));
`else
    check_eq("lock2_after", 64'(req_ready), 64'(2'b01));
`endif

    // Reset right after a locking read accept.
    step();
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h20, '0, '0);
    set_req(1, 1'b0, 1'b0, 1'b0, 8'h10, '0, '0);
    #1;
    check_eq("rst_mid_accept", 64'(req_ready), 64'(2'b01));
    step();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h20, 32'hFFFFFFFF, 4'hF);
    #1;
    check_eq("rst_mid_rsp_suppressed", 64'(rsp_valid), 64'(2'b00));
    check_eq("rst_mid_ready", 64'(req_ready), 64'(2'b00));
    check_eq("rst_mid_no_write", 64'(sram_csb0), 64'(1'b1));
    step();
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h20, '0, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h20, '0, '0);
    #1;
    check_eq("rst_after_rsp", 64'(rsp_valid), 64'(2'b00));
    check_eq("rst_lock_dropped", 64'(req_ready), 64'(2'b10));
    step();
    req_valid = '0;
    #1;
    check_eq("rst_mem_untouched", 64'(rsp_rdata), 64'(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
